// File: rtl/mem_burst_bridge_if.sv
// mem_burst_bridge_if
//   Bundles the two sides of the word-to-line bridge.
//   Core side : mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
//               (to bridge); mem_rdata, mem_resp (from bridge).
//   Memory side: pmem_address, pmem_read, pmem_write, pmem_wdata (from bridge);
//               pmem_rdata, pmem_resp (to bridge).
//   slave  : the bridge's view.
//   master : the view of whoever drives the core requests and models memory.
interface mem_burst_bridge_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/mem_burst_bridge.sv
// mem_burst_bridge
//   Serves single-word core reads/writes with 4 x 64-bit line bursts.
//   Writes are a line read-modify-write: read burst, byte-merge, write burst.
//   Ports: clk, rst (async, active high), bus (mem_burst_bridge_if.slave).
//   Optional macro MEM_BRIDGE_LINE_BUFFER_EN: keeps a valid/tag for the line
//   register so repeat accesses to the same 32-byte line skip the read burst.
module mem_burst_bridge (
  input  logic               clk,
  input  logic               rst,
  mem_burst_bridge_if.slave  bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  logic [1:0]   state;
  logic [1:0]   cnt;
  logic [255:0] line;
  logic [255:0] filled;
  logic [31:2]  addr_q;
  logic         wr_q;
  logic [3:0]   be_q;
  logic [31:0]  wdata_q;
  logic         req;
  logic         hit;
  logic         last_rd_beat;

  // Overlay the enabled byte lanes of d onto word w of line l.
  function automatic logic [255:0] merge_word(input logic [255:0] l,
                                              input logic [2:0]   w,
                                              input logic [3:0]   be,
                                              input logic [31:0]  d);
    logic [255:0] r;
    r = l;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[{w, b[1:0], 3'b000} +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Line contents including the beat arriving this cycle, so the final beat
  // can be merged and stored in the same edge.
  always_comb begin
    filled = line;
    filled[{cnt, 6'b0} +: 64] = bus.pmem_rdata;
  end

  assign req          = bus.mem_read | bus.mem_write;
  assign last_rd_beat = (state == RD_BURST) && bus.pmem_resp && (cnt == 2'd3);

`ifdef MEM_BRIDGE_LINE_BUFFER_EN
  logic         valid_q;
  logic [31:5]  tag_q;

  assign hit = valid_q && (tag_q == bus.mem_address[31:5]);

  // Only a completed read burst makes the line register a faithful copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else if (last_rd_beat) begin
      valid_q <= 1'b1;
      tag_q   <= addr_q[31:5];
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      line    <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr_q  <= bus.mem_address[31:2];
          wr_q    <= bus.mem_write;           // write wins over read
          be_q    <= bus.mem_byte_enable;
          wdata_q <= bus.mem_wdata;
          cnt     <= 2'd0;
          if (hit) begin
            if (bus.mem_write) begin
              line  <= merge_word(line, bus.mem_address[4:2],
                                  bus.mem_byte_enable, bus.mem_wdata);
              state <= WR_BURST;
            end else begin
              state <= RESP;
            end
          end else begin
            state <= RD_BURST;
          end
        end
        RD_BURST: if (bus.pmem_resp) begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (wr_q) begin
              line  <= merge_word(filled, addr_q[4:2], be_q, wdata_q);
              state <= WR_BURST;
            end else begin
              line  <= filled;
              state <= RESP;
            end
          end else begin
            line <= filled;
          end
        end
        WR_BURST: if (bus.pmem_resp) begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= RESP;
        end
        default: state <= IDLE;               // RESP: requests not sampled
      endcase
    end
  end

  // Outputs are gated by state so reset drives them all to zero at once.
  assign bus.pmem_read    = (state == RD_BURST);
  assign bus.pmem_write   = (state == WR_BURST);
  assign bus.pmem_wdata   = (state == WR_BURST) ? line[{cnt, 6'b0} +: 64] : 64'd0;
  assign bus.pmem_address = {addr_q[31:5], 5'b0};
  assign bus.mem_resp     = (state == RESP);
  assign bus.mem_rdata    = (state == RESP) ? line[{addr_q[4:2], 5'b0} +: 32] : 32'd0;
endmodule

// File: tb/tb_mem_burst_bridge.sv
// tb_mem_burst_bridge
//   Randomized scoreboard bench. A word-level reference memory predicts every
//   read/write result, burst beat count and latency; a beat-level physical
//   memory model answers the bursts with configurable wait states.
module tb_mem_burst_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_burst_bridge_if bus();
  mem_burst_bridge dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          lat;        // -1: not timed (wait states active)
    int          issue;
    int          beats0;
    int          exp_beats;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [0:255];   // word view of 0x000..0x3FF
  logic [63:0] phys    [0:127];   // beat view of the same range
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          total_beats = 0;
  int          last_beat_cyc = 0;
  int          overlap = 0;
  int          wmode = 0;         // 0 zero-wait, 1 random waits, 2 every third cycle
  int          beat = 0;
  int          strobe_cyc = 0;
  logic [31:0] exp_paddr = 32'd0;
`ifdef MEM_BRIDGE_LINE_BUFFER_EN
  bit          buf_valid = 1'b0;
  logic [31:5] buf_tag = '0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Physical memory: decides at the negedge whether the next edge takes a beat.
  always @(negedge clk) begin
    bit         go;
    logic [6:0] idx;
    if (rst) begin
      beat = 0;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = 64'd0;
    end else begin
      if (bus.pmem_read && bus.pmem_write) overlap++;
      go = 1'b0;
      if (bus.pmem_read || bus.pmem_write) begin
        strobe_cyc++;
        go = (wmode == 0) || (wmode == 2 && strobe_cyc % 3 == 0) ||
             (wmode == 1 && $urandom_range(0, 2) == 0);
      end
      if (go) begin
        checks++;
        if (bus.pmem_address != exp_paddr) begin
          errors++;
          $display("FAIL pmem_address: got %h required %h", bus.pmem_address, exp_paddr);
        end
        idx = {bus.pmem_address[9:5], beat[1:0]};
        if (bus.pmem_write) phys[idx] = bus.pmem_wdata;
        bus.pmem_rdata = phys[idx];
        bus.pmem_resp  = 1'b1;
        if (beat == 3) last_beat_cyc = cyc + 1;
        beat = (beat + 1) % 4;
        total_beats++;
      end else begin
        bus.pmem_resp = 1'b0;
      end
    end
  end

  // Monitor: every mem_resp pops one prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.mem_resp) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: mem_resp with rdata %h, required no response", bus.mem_rdata);
      end else begin
        e = sbq.pop_front();
        if (bus.mem_rdata !== e.rdata) begin
          errors++;
          $display("FAIL rdata addr=%h: got %h required %h", e.addr, bus.mem_rdata, e.rdata);
        end
        checks++;
        if (total_beats - e.beats0 != e.exp_beats) begin
          errors++;
          $display("FAIL beats addr=%h: got %0d required %0d", e.addr, total_beats - e.beats0, e.exp_beats);
        end
        if (e.lat >= 0) begin
          checks++;
          if (cyc - e.issue != e.lat) begin
            errors++;
            $display("FAIL latency addr=%h: got %0d required %0d", e.addr, cyc - e.issue, e.lat);
          end
        end
        if (e.exp_beats != 0) begin
          checks++;
          if (cyc != last_beat_cyc) begin
            errors++;
            $display("FAIL resp_after_beat addr=%h: resp cycle %0d required %0d", e.addr, cyc, last_beat_cyc);
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input bit rd, input bit wr,
                       input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    bit   hit;
    bit   got;
    @(negedge clk);
    hit = 1'b0;
`ifdef MEM_BRIDGE_LINE_BUFFER_EN
    hit = buf_valid && (buf_tag == a[31:5]);
    if (!hit) begin
      buf_valid = 1'b1;
      buf_tag   = a[31:5];
    end
`endif
    if (wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a[9:2]][b*8 +: 8] = wd[b*8 +: 8];
    e.addr      = a;
    e.rdata     = ref_mem[a[9:2]];
    e.exp_beats = hit ? (wr ? 4 : 0) : (wr ? 8 : 4);
    e.lat       = (wmode == 0) ? e.exp_beats + 1 : -1;
    e.issue     = cyc;
    e.beats0    = total_beats;
    exp_paddr   = {a[31:5], 5'b0};
    sbq.push_back(e);
    bus.mem_address     = a;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      got = bus.mem_resp;
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout addr=%h: no mem_resp within 400 cycles, required one", a);
      sbq.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [31:0] v [0:5];
    v[0] = {31'd0, bus.mem_resp};
    v[1] = bus.mem_rdata;
    v[2] = {31'd0, bus.pmem_read};
    v[3] = {31'd0, bus.pmem_write};
    v[4] = bus.pmem_wdata[31:0] | bus.pmem_wdata[63:32];
    v[5] = bus.pmem_address;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (v[k] !== 32'd0) begin
        errors++;
        $display("FAIL %s output%0d: got %h required 0", tag, k, v[k]);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [4:0]  ln;
    int          op;
    int          b0;

    bus.mem_address = 32'd0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_byte_enable = 4'd0;
    bus.mem_wdata = 32'd0;
    bus.pmem_rdata = 64'd0;
    bus.pmem_resp = 1'b0;

    for (int w = 0; w < 256; w++) ref_mem[w] = $urandom;
    for (int k = 0; k < 4; k++) begin
      ref_mem[64 + 2*k]     = {4{8'h11 * 8'(k + 1)}};
      ref_mem[64 + 2*k + 1] = {4{8'h11 * 8'(k + 1)}};
      ref_mem[128 + 2*k]     = 32'hFFFF_FFFF;
      ref_mem[128 + 2*k + 1] = 32'hFFFF_FFFF;
    end
    for (int w = 0; w < 256; w++) phys[w/2][(w%2)*32 +: 32] = ref_mem[w];

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Directed cases.
    wmode = 0;
    issue(32'h10C, 1, 0, 4'b0000, 32'd0);
    issue(32'h204, 0, 1, 4'b0010, 32'h0000AB00);
    wmode = 2;
    issue(32'h30C, 1, 0, 4'b0000, 32'd0);
    issue(32'h2E8, 0, 1, 4'b1001, 32'hA5C3_3C5A);
    wmode = 0;
    issue(32'h084, 1, 1, 4'b1111, 32'hDEAD_BEEF);

    // Reset in the middle of a read burst.
    @(negedge clk);
    bus.mem_address = 32'h140;
    bus.mem_read    = 1'b1;
    exp_paddr       = 32'h140;
    b0 = total_beats;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (total_beats - b0 >= 3) break;
    end
    rst = 1'b1;
    bus.mem_read = 1'b0;
    #1;
    check_outputs_zero("mid_burst_reset");
    sbq.delete();
`ifdef MEM_BRIDGE_LINE_BUFFER_EN
    buf_valid = 1'b0;
`endif
    @(negedge clk);
    #2;
    rst = 1'b0;
    issue(32'h140, 1, 0, 4'b0000, 32'd0);

    // Same-line repeat, then a different line.
    issue(32'h100, 1, 0, 4'b0000, 32'd0);
    issue(32'h104, 1, 0, 4'b0000, 32'd0);
    issue(32'h120, 1, 0, 4'b0000, 32'd0);
    issue(32'h124, 0, 1, 4'b0101, 32'h1234_5678);

    // Random traffic with line reuse and mixed wait states.
    ln = 5'd3;
    for (int n = 0; n < 150; n++) begin
      wmode = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) ln = 5'($urandom_range(0, 31));
      a  = {22'd0, ln, 3'($urandom), 2'($urandom)};
      op = $urandom_range(0, 2);
      issue(a, op != 1, op != 0, 4'($urandom), $urandom);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_resp: %0d predictions left, required 0", sbq.size());
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL rd_wr_overlap: %0d cycles with both strobes, required 0", overlap);
    end
    for (int w = 0; w < 256; w++) begin
      checks++;
      if (phys[w/2][(w%2)*32 +: 32] !== ref_mem[w]) begin
        errors++;
        $display("FAIL memory word %0d: got %h required %h", w, phys[w/2][(w%2)*32 +: 32], ref_mem[w]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
